// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 SRAM slave: response codes, FSM state
// encoding and default widths.
package axi_pkg;

    localparam int ID_W_DEF    = 8;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int LEN_W_DEF   = 4;
    localparam int SRAM_AW_DEF = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_REQ,
        S_R_DATA,
        S_W_DATA,
        S_W_RESP
    } slave_state_e;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating INCR bursts (up to 16 x 4-byte beats) onto a
// single-port word-wide SRAM macro. One transaction in flight at a time;
// a read wins a same-cycle tie with a write.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for AR or AW; ARREADY=1, AWREADY=~ARVALID
// S_R_REQ  | SRAM read strobe for the current word
// S_R_DATA | RVALID with SRAM DO; strobe held so DO stays stable on stall
// S_W_DATA | accepting W beats, each beat is an SRAM write in the same cycle
// S_W_RESP | BVALID with OKAY/SLVERR until BREADY
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int SRAM_AW = SRAM_AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  CS,
    output logic                  OE,
    output logic [DATA_W/8-1:0]   WEB,
    output logic [SRAM_AW-1:0]    A,
    output logic [DATA_W-1:0]     DI,
    input  logic [DATA_W-1:0]     DO
);

    slave_state_e       state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;

    // Byte-lane bits and bits above the SRAM window carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                                ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

    // ID is shared between R and B since reads and writes never overlap.
    assign BID   = id_q;
    assign RID   = id_q;
    assign RRESP = RESP_OKAY;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    // Next-state, handshake and SRAM strobe decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        err_d   = err_q;
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = RESP_OKAY;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        RDATA   = '0;
        CS      = 1'b0;
        OE      = 1'b0;
        WEB     = '1;
        A       = '0;
        DI      = '0;

        case (state_q)
            S_IDLE: begin
                // Readies held low while rst is asserted so no handshake is lost.
                ARREADY = !rst;
                AWREADY = !rst && !ARVALID;
                if (!rst && ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[SRAM_AW+1:2];
                    cnt_d   = ARLEN;
                    state_d = S_R_REQ;
                end else if (!rst && AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[SRAM_AW+1:2];
                    cnt_d   = AWLEN;
                    err_d   = 1'b0;
                    state_d = S_W_DATA;
                end
            end

            S_R_REQ: begin
                CS      = 1'b1;
                OE      = 1'b1;
                A       = addr_q;
                state_d = S_R_DATA;
            end

            S_R_DATA: begin
                CS     = 1'b1;
                OE     = 1'b1;
                A      = addr_q;
                RVALID = 1'b1;
                RDATA  = DO;
                RLAST  = (cnt_q == '0);
                if (RREADY) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_R_REQ;
                    end
                end
            end

            S_W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    CS  = 1'b1;
                    WEB = ~WSTRB;
                    A   = addr_q;
                    DI  = WDATA;
                    // Beat count is authoritative; a misplaced WLAST only flags the response.
                    if (WLAST != (cnt_q == '0)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_d = S_W_RESP;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end

            S_W_RESP: begin
                BVALID = 1'b1;
                BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (BREADY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
